// File: rtl/bus_alu_pkg.sv
// Shared constants for the bus ALU sequencer: opcodes, FSM state encodings, defaults.
// MUL support is selected by BUS_ALU_MUL_EN; without it opcode 111 is rejected.
package bus_alu_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int NUM_REGS_DEF = 4;

`ifdef BUS_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_A      = 3'd1;
    localparam logic [2:0] S_RD_B      = 3'd2;
    localparam logic [2:0] S_EXEC      = 3'd3;
    localparam logic [2:0] S_WR_SETUP  = 3'd4;
    localparam logic [2:0] S_WR_STROBE = 3'd5;

    function automatic logic op_legal(input logic [2:0] op);
        return (op != OP_MUL) || MUL_EN;
    endfunction

endpackage

// File: rtl/bus_alu_core.sv
// Combinational ALU datapath: (opcode, a, b) -> (res, carry, zero). MUL only with BUS_ALU_MUL_EN.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the sequencer samples the outputs when it needs them.
module bus_alu_core
    import bus_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero
);

    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (opcode)
            OP_ADD: {carry, res} = {1'b0, a} + {1'b0, b};
            // The extra top bit of the widened difference is the borrow (a < b).
            OP_SUB: {carry, res} = {1'b0, a} - {1'b0, b};
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: res = a << b[3:0];
            OP_SHR: res = a >> b[3:0];
`ifdef BUS_ALU_MUL_EN
            OP_MUL: res = a * b;
`endif
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: rtl/bus_alu.sv
// Bus ALU sequencer: reads two registers over the shared bus, computes, writes back (BUS_ALU_MUL_EN adds MUL).
// Latency: start in cycle 0, done pulse in cycle 6; illegal requests answer done/err in cycle 1.
// Backpressure: start is ignored while busy; nothing is queued.
module bus_alu
    import bus_alu_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [3:0]       src_a,
    input  logic [3:0]       src_b,
    input  logic [3:0]       dst,
    inout  wire  [WIDTH-1:0] bus,
    output logic [3:0]       reg_index,
    output logic             reg_rEn,
    output logic             reg_wEn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam logic [4:0] NREG = 5'(NUM_REGS);

    logic [2:0]       state, next_state;
    logic [2:0]       op_q;
    logic [3:0]       src_b_q, dst_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q, zero_q;
    logic [3:0]       idx_q;
    logic             ren_q, wen_q, drv_q, done_q, err_q;
    logic [WIDTH-1:0] core_res;
    logic             core_carry, core_zero;
    logic             accept, req_legal;

    assign accept    = (state == S_IDLE) && start;
    assign req_legal = op_legal(opcode)
                    && ({1'b0, src_a} < NREG)
                    && ({1'b0, src_b} < NREG)
                    && ({1'b0, dst}   < NREG);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (accept && req_legal) next_state = S_RD_A;
            S_RD_A:      next_state = S_RD_B;
            S_RD_B:      next_state = S_EXEC;
            S_EXEC:      next_state = S_WR_SETUP;
            S_WR_SETUP:  next_state = S_WR_STROBE;
            S_WR_STROBE: next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    bus_alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .res    (core_res),
        .carry  (core_carry),
        .zero   (core_zero)
    );

    // Bus-side controls are registered from next_state so strobes and drive enables are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= OP_ADD;
            src_b_q <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            drv_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (state == S_WR_STROBE) || (accept && !req_legal);
            err_q  <= accept && !req_legal;
            ren_q  <= (next_state == S_RD_A) || (next_state == S_RD_B);
            wen_q  <= (next_state == S_WR_STROBE);
            drv_q  <= (next_state == S_WR_SETUP) || (next_state == S_WR_STROBE);

            if (accept) begin
                op_q    <= opcode;
                src_b_q <= src_b;
                dst_q   <= dst;
            end

            case (next_state)
                S_RD_A:                   idx_q <= src_a;
                S_RD_B:                   idx_q <= src_b_q;
                S_WR_SETUP, S_WR_STROBE:  idx_q <= dst_q;
                default:                  idx_q <= '0;
            endcase

            if (state == S_RD_A) a_q <= bus;
            if (state == S_RD_B) b_q <= bus;

            if (state == S_EXEC) begin
                res_q   <= core_res;
                carry_q <= core_carry;
                zero_q  <= core_zero;
            end
        end
    end

    assign bus       = drv_q ? res_q : {WIDTH{1'bz}};
    assign reg_index = idx_q;
    assign reg_rEn   = ren_q;
    assign reg_wEn   = wen_q;
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign result    = res_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: doc/bus_alu.md
# bus_alu

Multi-cycle 16-bit ALU sequencer on the shared tristate register bus. It sits directly downstream of the register file. It reads two operands from the register file by driving its index/rEn lines, computes a result, and writes the result back through the same bus with a clean wEn strobe. It is the first execution stage of the microcontroller datapath and is started by the instruction decoder through a start/done handshake.

## Interface
- WIDTH, 16, data/bus width
- NUM_REGS, 4, number of valid register-file entries; indices >= NUM_REGS are illegal
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request, sampled only when busy=0
- opcode  in  3  operation, sampled with start
- src_a  in  4  register index of operand A, sampled with start
- src_b  in  4  register index of operand B, sampled with start
- dst  in  4  register index of result, sampled with start
- bus  inout  WIDTH  shared register bus; driven only in write states, else high-Z
- reg_index  out  4  register-file index
- reg_rEn  out  1  register-file read enable
- reg_wEn  out  1  register-file write strobe (file latches on rising edge)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on illegal index/opcode
- result  out  WIDTH  last computed result, held
- carry  out  1  carry/borrow flag of last op, held
- zero  out  1  result==0 flag of last op, held

## Operation
- Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL (A << B[3:0]), 110 SHR logical (A >> B[3:0]), 111 MUL (low WIDTH bits of A*B).
- carry: ADD = carry-out of WIDTH+1-bit sum; SUB = borrow (1 when A<B unsigned); all others 0.
- zero = (result == 0). Flags and result update in EXEC only and hold until next EXEC.
- FSM: IDLE -> RD_A -> RD_B -> EXEC -> WR_SETUP -> WR_STROBE -> IDLE.
- IDLE: bus released, rEn=wEn=0, reg_index=0. On start with busy=0, latch opcode/indices. If any index >= NUM_REGS, or opcode illegal (see Configuration), stay IDLE, pulse done and err next cycle, no bus activity, flags unchanged.
- RD_A: reg_index=src_a, reg_rEn=1, capture bus into A at end of cycle. RD_B: same for src_b into B.
- EXEC: rEn=0, bus released (turnaround cycle), compute, register result/flags.
- WR_SETUP: reg_index=dst, drive bus=result, wEn=0. WR_STROBE: keep index and bus, wEn=1.
- Return to IDLE: wEn=0, bus released, done=1 for one cycle.
- Invariant: reg_rEn and bus drive never active in the same cycle.
- start while busy=1: ignored, not queued.
- dst equal to src_a/src_b: legal; operands are already captured.

## Timing
- Reset values: busy=0, done=0, err=0, reg_rEn=0, reg_wEn=0, reg_index=0, result=0, carry=0, zero=0, bus high-Z, state IDLE.
- Start sampled in cycle 0. busy=1 in cycles 1-5: RD_A=1, RD_B=2, EXEC=3, WR_SETUP=4, WR_STROBE=5. done=1 in cycle 6.
- Back-to-back: start may be asserted in cycle 6 (busy=0). Throughput is one op per 6 cycles.
- Illegal request: done=err=1 in cycle 1, busy stays 0.
- reset asserted in any state: at next edge go to IDLE, release bus, drop wEn/rEn, no done. A partial write is abandoned.

## Configuration
- BUS_ALU_MUL_EN defined: opcode 111 performs MUL.
- Undefined: opcode 111 is illegal and takes the err path. No multiplier is synthesized.

## Structure
- Package bus_alu_pkg: opcode constants, FSM state enum, WIDTH default.
- Sub-module bus_alu_core: purely combinational (opcode, A, B) -> (result, carry, zero), with MUL inside the BUS_ALU_MUL_EN guard. The FSM, bus drive and handshake live in bus_alu.

## Test plan
- Preload R0=0x0003, R1=0x0005; ADD src_a=0, src_b=1, dst=2 -> R2=0x0008, carry=0, zero=0, done in cycle 6, wEn high in cycle 5 only.
- R0=0xFFFF, R1=0x0001, ADD dst=3 -> R3=0x0000, carry=1, zero=1. Then SUB R1-R0 -> 0x0002, carry=1 (borrow).
- SHL with A=0x0001, B=0x0004 -> 0x0010. MUL 0x0100*0x0100 -> 0x0000 with macro; without macro, err=1 and no wEn.
- src_b=4 -> done=err=1 in cycle 1, rEn/wEn never asserted, flags unchanged.
- start re-pulsed during busy -> ignored, exactly one write; reset asserted in cycle 4 -> wEn never rises, bus high-Z next cycle, no done.
- Bus monitor across all tests: never X or contention (rEn=1 while bus driven).
